// File: rtl/v_inst_queue_pkg.sv
// Shared defaults and sizing helper for the vector instruction queue.
package v_inst_queue_pkg;

  localparam int VQ_DEPTH  = 4;
  localparam int VQ_INST_W = 32;
  localparam int VQ_XLEN   = 64;

  function automatic int vq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/v_sync_fifo.sv
// Synchronous circular-buffer FIFO with first-word-fall-through head and occupancy count.
module v_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign empty     = (count_q == {CNT_W{1'b0}});
  assign do_push_s = push && (count_q != CNT_W'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign pop_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/v_inst_queue.sv
// Vector instruction queue: FIFO plus a one-entry issue stage that feeds the vector core
// and answers its rs1 reads from the value captured at dispatch.
module v_inst_queue
  import v_inst_queue_pkg::*;
#(
  parameter  int DEPTH  = VQ_DEPTH,
  parameter  int INST_W = VQ_INST_W,
  parameter  int XLEN   = VQ_XLEN,
  localparam int CNT_W  = vq_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [INST_W-1:0] s_inst,
  input  logic [XLEN-1:0]   s_rs1_data,
  input  logic              v_ready,
  output logic [INST_W-1:0] v_inst,
  input  logic              vec_rs1_r_ena,
  input  logic [4:0]        vec_rs1_r_addr,
  output logic [XLEN-1:0]   vec_rs1_data,
  output logic [CNT_W-1:0]  vq_count,
  output logic              vq_idle
);

  localparam int ENT_W = INST_W + XLEN;

  logic              push_s, consume_s, iss_free_s, bypass_s;
  logic              fifo_push_s, fifo_pop_s, fifo_empty_s;
  logic [ENT_W-1:0]  head_s;
  logic [CNT_W-1:0]  fifo_cnt_s, count_s;
  logic              iss_valid_q, iss_valid_d;
  logic [INST_W-1:0] iss_inst_q, iss_inst_d;
  logic [XLEN-1:0]   iss_rs1_q, iss_rs1_d;
  logic              unused_rs1_req_s;

  // The rs1 return path always answers for the issued instruction; the request is informational.
  assign unused_rs1_req_s = ^{vec_rs1_r_ena, vec_rs1_r_addr};

  // Occupancy counts the issue stage, so s_ready depends on flops only.
  assign count_s  = fifo_cnt_s + CNT_W'(iss_valid_q);
  assign s_ready  = (count_s < CNT_W'(DEPTH));
  assign vq_count = count_s;
  assign vq_idle  = (count_s == {CNT_W{1'b0}});

  assign push_s      = s_valid && s_ready;
  assign consume_s   = iss_valid_q && v_ready;
  assign iss_free_s  = !iss_valid_q || v_ready;
  assign fifo_pop_s  = iss_free_s && !fifo_empty_s;
  assign bypass_s    = iss_free_s && fifo_empty_s && push_s;
  assign fifo_push_s = push_s && !bypass_s;

  v_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_s),
    .push_data ({s_inst, s_rs1_data}),
    .pop       (fifo_pop_s),
    .pop_data  (head_s),
    .count     (fifo_cnt_s),
    .empty     (fifo_empty_s)
  );

  // A push into an empty queue loads the issue stage directly, giving one-cycle latency.
  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_inst_d  = iss_inst_q;
    iss_rs1_d   = iss_rs1_q;
    if (fifo_pop_s) begin
      iss_valid_d             = 1'b1;
      {iss_inst_d, iss_rs1_d} = head_s;
    end else if (bypass_s) begin
      iss_valid_d = 1'b1;
      iss_inst_d  = s_inst;
      iss_rs1_d   = s_rs1_data;
    end else if (consume_s) begin
      iss_valid_d = 1'b0;
    end else begin
      iss_valid_d = iss_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid_q <= 1'b0;
      iss_inst_q  <= {INST_W{1'b0}};
      iss_rs1_q   <= {XLEN{1'b0}};
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_inst_q  <= iss_inst_d;
      iss_rs1_q   <= iss_rs1_d;
    end
  end

  // The vector core decodes every cycle, so anything not being issued reads as a NOP.
  assign v_inst       = (iss_valid_q && v_ready) ? iss_inst_q : {INST_W{1'b0}};
  assign vec_rs1_data = iss_valid_q ? iss_rs1_q : {XLEN{1'b0}};

endmodule

// File: tb/tb_v_inst_queue.sv
// Randomised and directed bench for v_inst_queue against a queue-based reference model.
module tb_v_inst_queue;

  localparam int DEPTH  = 4;
  localparam int INST_W = 32;
  localparam int XLEN   = 64;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid, s_ready;
  logic [INST_W-1:0] s_inst;
  logic [XLEN-1:0]   s_rs1_data;
  logic              v_ready;
  logic [INST_W-1:0] v_inst;
  logic              vec_rs1_r_ena;
  logic [4:0]        vec_rs1_r_addr;
  logic [XLEN-1:0]   vec_rs1_data;
  logic [CW-1:0]     vq_count;
  logic              vq_idle;

  always #5 clk = ~clk;

  v_inst_queue #(.DEPTH(DEPTH), .INST_W(INST_W), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_inst         (s_inst),
    .s_rs1_data     (s_rs1_data),
    .v_ready        (v_ready),
    .v_inst         (v_inst),
    .vec_rs1_r_ena  (vec_rs1_r_ena),
    .vec_rs1_r_addr (vec_rs1_r_addr),
    .vec_rs1_data   (vec_rs1_data),
    .vq_count       (vq_count),
    .vq_idle        (vq_idle)
  );

  typedef struct {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   rs1;
  } ent_t;

  ent_t mq[$];   // every instruction held by the queue, head first
  ent_t src[$];  // instructions the scalar side still has to deliver

  int  n_cmp = 0;
  int  n_err = 0;
  bit  model_ok = 1'b0;
  bit  last_accept = 1'b0;
  bit  hold_s;
  int  msize;
  logic [INST_W-1:0] exp_inst;
  logic [XLEN-1:0]   exp_rs1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Mid-cycle: compare against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    msize = mq.size();
    if (model_ok) begin
      exp_inst = (msize > 0 && v_ready) ? mq[0].inst : '0;
      exp_rs1  = (msize > 0) ? mq[0].rs1 : '0;
      chk("v_inst", 64'(v_inst), 64'(exp_inst));
      chk("vec_rs1_data", vec_rs1_data, exp_rs1);
      chk("s_ready", 64'(s_ready), 64'(msize < DEPTH));
      chk("vq_count", 64'(vq_count), 64'(msize));
      chk("vq_idle", 64'(vq_idle), 64'(msize == 0));
    end
    last_accept = s_valid && s_ready;
    if (rst) begin
      mq.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (msize > 0 && v_ready) void'(mq.pop_front());
      if (s_valid && msize < DEPTH) mq.push_back('{s_inst, s_rs1_data});
    end
  end

  // One source cycle: retire an accepted offer, keep an unaccepted one, else maybe offer the next.
  task automatic cycle_src(input bit want, input bit vr);
    @(posedge clk);
    if (s_valid && last_accept && src.size() > 0) void'(src.pop_front());
    hold_s = s_valid && !last_accept;
    #1;
    s_valid = (hold_s || want) && (src.size() > 0);
    if (s_valid) begin
      s_inst     = src[0].inst;
      s_rs1_data = src[0].rs1;
    end else begin
      s_inst     = $urandom;
      s_rs1_data = {$urandom, $urandom};
    end
    v_ready        = vr;
    vec_rs1_r_ena  = $urandom_range(1);
    vec_rs1_r_addr = 5'($urandom_range(31));
  endtask

  task automatic mid_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_inst = '0; s_rs1_data = '0;
    v_ready = 1'b1; vec_rs1_r_ena = 1'b0; vec_rs1_r_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mid_cycle();
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_v_inst", 64'(v_inst), 64'd0);
    chk("rst_vq_idle", 64'(vq_idle), 64'd1);
    chk("rst_vq_count", 64'(vq_count), 64'd0);

    // Single instruction: visible for exactly one cycle after its push edge.
    src.push_back('{32'h0200_7057, 64'h0000_0000_DEAD_BEEF});
    cycle_src(1'b1, 1'b1);
    mid_cycle();
    chk("single_push_cycle_v_inst", 64'(v_inst), 64'd0);
    cycle_src(1'b0, 1'b1);
    mid_cycle();
    chk("single_v_inst", 64'(v_inst), 64'h0000_0000_0200_7057);
    chk("single_rs1", vec_rs1_data, 64'h0000_0000_DEAD_BEEF);
    cycle_src(1'b0, 1'b1);
    mid_cycle();
    chk("single_after_v_inst", 64'(v_inst), 64'd0);
    chk("single_after_idle", 64'(vq_idle), 64'd1);

    // Fill with the vector core stalled; the fifth offer must be held back.
    for (int k = 0; k < 5; k++) src.push_back('{32'h1000_0000 + 32'(k), 64'(k) + 64'h100});
    repeat (6) cycle_src(1'b1, 1'b0);
    mid_cycle();
    chk("full_count", 64'(vq_count), 64'd4);
    chk("full_s_ready", 64'(s_ready), 64'd0);
    chk("full_held_valid", 64'(s_valid), 64'd1);
    cycle_src(1'b1, 1'b1);
    mid_cycle();
    chk("release_first", 64'(v_inst), 64'h0000_0000_1000_0000);
    repeat (7) cycle_src(1'b1, 1'b1);

    // Back-to-back streaming with wrap-around, then a stall in the middle of a stream.
    for (int k = 0; k < 10; k++) src.push_back('{32'h2000_0000 + 32'(k), {32'hA5A5_0000, 32'(k)}});
    repeat (14) cycle_src(1'b1, 1'b1);
    for (int k = 0; k < 8; k++) src.push_back('{32'h3000_0000 + 32'(k), {32'h5A5A_0000, 32'(k)}});
    repeat (3) cycle_src(1'b1, 1'b1);
    repeat (3) cycle_src(1'b1, 1'b0);
    repeat (10) cycle_src(1'b1, 1'b1);

    // Reset with three entries queued, then resume.
    for (int k = 0; k < 3; k++) src.push_back('{32'h4000_0000 + 32'(k), 64'(k)});
    repeat (4) cycle_src(1'b1, 1'b0);
    mid_cycle();
    chk("pre_reset_count", 64'(vq_count), 64'd3);
    @(posedge clk);
    #1 rst = 1'b1; s_valid = 1'b0; v_ready = 1'b1; src.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    mid_cycle();
    chk("post_reset_count", 64'(vq_count), 64'd0);
    chk("post_reset_v_inst", 64'(v_inst), 64'd0);
    src.push_back('{32'h0000_1057, 64'h1234_5678_9ABC_DEF0});
    cycle_src(1'b1, 1'b1);
    cycle_src(1'b0, 1'b1);
    mid_cycle();
    chk("post_reset_issue", 64'(v_inst), 64'h0000_0000_0000_1057);
    chk("post_reset_rs1", vec_rs1_data, 64'h1234_5678_9ABC_DEF0);

    // Random traffic on both sides.
    for (int k = 0; k < 300; k++) src.push_back('{32'($urandom), {$urandom, $urandom}});
    repeat (600) cycle_src($urandom_range(3) != 0, $urandom_range(2) != 0);
    repeat (400) begin
      if (src.size() == 0 && !s_valid) break;
      cycle_src(1'b1, 1'b1);
    end
    chk("source_drained", 64'(src.size()), 64'd0);
    repeat (DEPTH + 2) cycle_src(1'b0, 1'b1);
    mid_cycle();
    chk("final_idle", 64'(vq_idle), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
